// File: rtl/dma_priority.sv
// rtl/dma_priority.sv - DMA channel arbiter and HRQ/HLDA bus-request FSM (option: DMA_ROTATING_PRIORITY_EN)
module dma_priority #(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic           HLDA,
  input  logic [NCH-1:0] mask,
  input  logic [NCH-1:0] sw_req,
  input  logic           cmd_ctrl_dis,
  input  logic           cmd_rot_pri,
  input  logic           cmd_dreq_low,
  input  logic           cmd_dack_high,
  input  logic           svc_done,
  output logic           HRQ,
  output logic [NCH-1:0] DACK,
  output logic [1:0]     act_ch,
  output logic           ch_valid
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD_REQ = 2'd1,
    S_ACTIVE   = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [NCH-1:0] dreq_s;
  logic [NCH-1:0] pend;
  logic           pend_any;
  logic [1:0]     base;
  logic [1:0]     idx;
  logic [1:0]     win;
  logic           found;
  logic           hrq_n;
  logic           valid_n;
  logic [1:0]     ch_n;
  logic [NCH-1:0] dack_n;

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [1:0]     ptr, ptr_n;
`else
  logic           unused_rot_pri;
  assign unused_rot_pri = cmd_rot_pri;
`endif

  // Normalise DREQ polarity and register it once.
  always_ff @(posedge CLK) begin
    if (RESET) dreq_s <= '0;
    else       dreq_s <= cmd_dreq_low ? ~DREQ : DREQ;
  end

  assign pend     = (dreq_s & ~mask) | sw_req;
  assign pend_any = |pend;

  // Pick the first pending channel starting from the priority base, wrapping mod 4.
  always_comb begin
`ifdef DMA_ROTATING_PRIORITY_EN
    base = cmd_rot_pri ? ptr : 2'd0;
`else
    base = 2'd0;
`endif
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      idx = base + 2'(i);
      if (!found && pend[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next state and next values of the registered grant/handshake outputs.
  always_comb begin
    state_n = state;
    hrq_n   = HRQ;
    valid_n = ch_valid;
    ch_n    = act_ch;
`ifdef DMA_ROTATING_PRIORITY_EN
    ptr_n   = ptr;
`endif
    case (state)
      S_IDLE: begin
        // HLDA guard keeps a fresh HRQ off the bus until the CPU has let go.
        if (pend_any && !cmd_ctrl_dis && !HLDA) begin
          state_n = S_HOLD_REQ;
          hrq_n   = 1'b1;
        end
      end
      S_HOLD_REQ: begin
        if (HLDA && pend_any) begin
          ch_n    = win;
          valid_n = 1'b1;
          state_n = S_ACTIVE;
        end else if (!pend_any) begin
          hrq_n   = 1'b0;
          state_n = S_RELEASE;
        end
      end
      S_ACTIVE: begin
        // svc_done wins over a simultaneous HLDA drop so rotation still advances.
        if (svc_done) begin
          valid_n = 1'b0;
          hrq_n   = 1'b0;
          state_n = S_RELEASE;
`ifdef DMA_ROTATING_PRIORITY_EN
          if (cmd_rot_pri) ptr_n = act_ch + 2'd1;
`endif
        end else if (!HLDA) begin
          valid_n = 1'b0;
          hrq_n   = 1'b0;
          state_n = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!HLDA) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    dack_n = {NCH{~cmd_dack_high}} ^ (valid_n ? (NCH'(1) << ch_n) : '0);
  end

  // State, grant and DACK registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      HRQ      <= 1'b0;
      DACK     <= '1;
      act_ch   <= 2'd0;
      ch_valid <= 1'b0;
`ifdef DMA_ROTATING_PRIORITY_EN
      ptr      <= 2'd0;
`endif
    end else begin
      state    <= state_n;
      HRQ      <= hrq_n;
      DACK     <= dack_n;
      act_ch   <= ch_n;
      ch_valid <= valid_n;
`ifdef DMA_ROTATING_PRIORITY_EN
      ptr      <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_dma_priority.sv
// tb/tb_dma_priority.sv - randomized and directed checks of dma_priority against a behavioural model
module tb_dma_priority;

`ifdef DMA_ROTATING_PRIORITY_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = '0;
  logic       HLDA = 1'b0;
  logic [3:0] mask = '0;
  logic [3:0] sw_req = '0;
  logic       cmd_ctrl_dis = 1'b0;
  logic       cmd_rot_pri = 1'b0;
  logic       cmd_dreq_low = 1'b0;
  logic       cmd_dack_high = 1'b0;
  logic       svc_done = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] act_ch;
  logic       ch_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: phase 0 idle, 1 requesting, 2 granted, 3 releasing
  int       m_phase = 0;
  bit [3:0] m_dreq_s = '0;
  bit       m_hrq = 0;
  bit       m_valid = 0;
  int       m_ch = 0;
  int       m_ptr = 0;
  bit [3:0] m_dack = 4'hf;

  always #5 CLK = ~CLK;

  dma_priority #(.NCH(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .mask(mask), .sw_req(sw_req),
    .cmd_ctrl_dis(cmd_ctrl_dis), .cmd_rot_pri(cmd_rot_pri), .cmd_dreq_low(cmd_dreq_low),
    .cmd_dack_high(cmd_dack_high), .svc_done(svc_done), .HRQ(HRQ), .DACK(DACK),
    .act_ch(act_ch), .ch_valid(ch_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit [3:0] p, input int start);
    for (int i = 0; i < 4; i++)
      if (p[(start + i) % 4]) return (start + i) % 4;
    return 0;
  endfunction

  task automatic model_edge();
    bit [3:0] pend;
    int       start;
    pend  = (m_dreq_s & ~mask) | sw_req;
    start = (ROT_EN && cmd_rot_pri) ? m_ptr : 0;
    if (RESET) begin
      m_phase = 0; m_dreq_s = '0; m_hrq = 0; m_valid = 0; m_ch = 0; m_ptr = 0; m_dack = 4'hf;
      return;
    end
    m_dreq_s = cmd_dreq_low ? ~DREQ : DREQ;
    case (m_phase)
      0: if (pend != 0 && !cmd_ctrl_dis && !HLDA) begin m_phase = 1; m_hrq = 1; end
      1: if (HLDA && pend != 0) begin
           m_ch = pick(pend, start); m_valid = 1; m_phase = 2;
         end else if (pend == 0) begin
           m_hrq = 0; m_phase = 3;
         end
      2: if (svc_done) begin
           m_valid = 0; m_hrq = 0; m_phase = 3;
           if (ROT_EN && cmd_rot_pri) m_ptr = (m_ch + 1) % 4;
         end else if (!HLDA) begin
           m_valid = 0; m_hrq = 0; m_phase = 3;
         end
      default: if (!HLDA) m_phase = 0;
    endcase
    m_dack = (cmd_dack_high ? 4'h0 : 4'hf) ^ (m_valid ? 4'(1 << m_ch) : 4'h0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    model_edge();
    check("hrq", HRQ, m_hrq);
    check("dack", DACK, m_dack);
    check("act_ch", act_ch, m_ch);
    check("ch_valid", ch_valid, m_valid);
  endtask

  task automatic do_reset();
    DREQ = '0; HLDA = 0; mask = '0; sw_req = '0; svc_done = 0;
    cmd_ctrl_dis = 0; cmd_rot_pri = 0; cmd_dreq_low = 0; cmd_dack_high = 0;
    RESET = 1;
    step();
    RESET = 0;
  endtask

  task automatic wait_hrq();
    for (int i = 0; i < 8 && !HRQ; i++) step();
    check("hrq_wait", HRQ, 1);
  endtask

  task automatic serve(output logic [1:0] ch);
    wait_hrq();
    HLDA = 1;
    step();
    ch = act_ch;
    svc_done = 1;
    step();
    svc_done = 0;
    HLDA = 0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic [1:0] ch;

    // reset state
    do_reset();
    check("rst_hrq", HRQ, 0);
    check("rst_dack", DACK, 4'b1111);
    check("rst_valid", ch_valid, 0);
    check("rst_act_ch", act_ch, 0);

    // request latency and grant of ch2
    DREQ = 4'b0100;
    step();
    check("lat_k", HRQ, 0);
    step();
    check("lat_k1", HRQ, 1);
    HLDA = 1;
    step();
    check("t1_dack", DACK, 4'b1011);
    check("t1_ch", act_ch, 2);
    check("t1_valid", ch_valid, 1);
    svc_done = 1;
    step();
    svc_done = 0;
    check("t1_rel_hrq", HRQ, 0);
    check("t1_rel_dack", DACK, 4'b1111);
    HLDA = 0; DREQ = '0;
    step(); step();

    // fixed priority repeats the same winner
    DREQ = 4'b1010;
    serve(ch); check("fix_a", ch, 1);
    serve(ch); check("fix_b", ch, 1);

    // rotating priority walks the channels
    if (ROT_EN) begin
      do_reset();
      cmd_rot_pri = 1; DREQ = 4'b1111;
      for (int i = 0; i < 5; i++) begin
        serve(ch);
        check("rot_order", ch, i % 4);
      end
    end

    // masked hardware request ignored, software request is not
    do_reset();
    mask = 4'b0001; DREQ = 4'b0001;
    repeat (4) step();
    check("mask_hrq", HRQ, 0);
    sw_req = 4'b0001;
    serve(ch); check("swreq_ch", ch, 0);

    // inverted polarities and CPU abort
    do_reset();
    cmd_dreq_low = 1; cmd_dack_high = 1; DREQ = 4'b0111;
    step();
    check("pol_idle_dack", DACK, 4'b0000);
    wait_hrq();
    HLDA = 1;
    step();
    check("pol_ch", act_ch, 3);
    check("pol_dack", DACK, 4'b1000);
    HLDA = 0;
    step();
    check("abort_dack", DACK, 4'b0000);
    check("abort_hrq", HRQ, 0);

    // reset mid-transfer
    do_reset();
    DREQ = 4'b0001;
    wait_hrq();
    HLDA = 1;
    step();
    RESET = 1;
    step();
    check("midrst_hrq", HRQ, 0);
    check("midrst_dack", DACK, 4'b1111);
    check("midrst_valid", ch_valid, 0);
    RESET = 0; HLDA = 0; DREQ = '0;
    step();

    // randomized traffic with a simple CPU model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 31) == 0) sw_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 63) == 0) cmd_rot_pri = 1'($urandom);
      if ($urandom_range(0, 127) == 0) cmd_dreq_low = 1'($urandom);
      if ($urandom_range(0, 63) == 0) cmd_dack_high = 1'($urandom);
      if ($urandom_range(0, 63) == 0) cmd_ctrl_dis = ($urandom_range(0, 3) == 0);
      if (!m_hrq && HLDA && $urandom_range(0, 1) == 0) HLDA = 0;
      else if (m_hrq && !HLDA && $urandom_range(0, 2) == 0) HLDA = 1;
      else if (HLDA && m_valid && $urandom_range(0, 29) == 0) HLDA = 0;
      svc_done = (m_valid && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
      RESET = ($urandom_range(0, 499) == 0);
      step();
    end
    RESET = 0; svc_done = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
